// File: rtl/mac_exec_unit_if.sv
// Request / write-back bundle between the issue stage and the multiply/MAC execute unit.
interface mac_exec_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int ACC_W  = 2*DATA_W
);
    logic                     start;
    logic [1:0]               op;
    logic signed [DATA_W-1:0] op_a;
    logic signed [DATA_W-1:0] op_b;
    logic [ADDR_W-1:0]        rd_addr;
    logic                     flush;
    logic                     ready;
    logic                     busy;
    logic                     done;
    logic                     wb_en;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic signed [ACC_W-1:0]  acc_out;

    modport master (
        output start, op, op_a, op_b, rd_addr, flush,
        input  ready, busy, done, wb_en, wb_addr, wb_data, acc_out
    );

    modport slave (
        input  start, op, op_a, op_b, rd_addr, flush,
        output ready, busy, done, wb_en, wb_addr, wb_data, acc_out
    );
endinterface

// File: rtl/mac_exec_unit.sv
// Iterative radix-2 signed multiply / multiply-accumulate unit with a private accumulator,
// driving the register-file write port through a one-cycle write-back state.
module mac_exec_unit #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int ACC_W  = 2*DATA_W
) (
    input logic           clk,
    input logic           reset,
    mac_exec_unit_if.slave bus
);
    localparam int PROD_W = 2*DATA_W;
    localparam int CNT_W  = $clog2(DATA_W);

    localparam logic [1:0] OP_MUL  = 2'b00;
    localparam logic [1:0] OP_MULH = 2'b01;
    localparam logic [1:0] OP_MAC  = 2'b10;
    localparam logic [1:0] OP_CLR  = 2'b11;

    typedef enum logic [1:0] {IDLE, CALC, FIX, WB} state_t;

    state_t                   state, state_n;
    logic [CNT_W-1:0]         count;
    logic [PROD_W-1:0]        mcand;
    logic [PROD_W-1:0]        prod;
    logic [DATA_W-1:0]        mplier;
    logic                     neg;
    logic [1:0]               op_lat;
    logic [ADDR_W-1:0]        rd_lat;
    logic signed [ACC_W-1:0]  acc;
    logic signed [ACC_W-1:0]  acc_sum;
    logic signed [PROD_W-1:0] product;
    logic [ADDR_W-1:0]        wb_addr;
    logic [DATA_W-1:0]        wb_data;
    logic                     ready;
    logic                     accept;
    logic                     last_step;

    // |x| fits in DATA_W unsigned bits even for the most negative operand.
    function automatic logic [DATA_W-1:0] magnitude(input logic signed [DATA_W-1:0] x);
        return x[DATA_W-1] ? unsigned'(-x) : unsigned'(x);
    endfunction

    function automatic logic signed [PROD_W-1:0] apply_sign(input logic [PROD_W-1:0] mag,
                                                            input logic              negate);
        return negate ? -signed'(mag) : signed'(mag);
    endfunction

    assign ready     = (state == IDLE) || (state == WB);
    assign accept    = bus.start && ready && !bus.flush;
    assign last_step = (count == CNT_W'(DATA_W-1));
    assign product   = apply_sign(prod, neg);
    assign acc_sum   = acc + ACC_W'(product);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE, WB: begin
                if (accept) state_n = (bus.op == OP_CLR) ? WB : CALC;
                else        state_n = IDLE;
            end
            CALC: begin
                if (bus.flush)     state_n = IDLE;
                else if (last_step) state_n = FIX;
            end
            FIX:     state_n = bus.flush ? IDLE : WB;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count   <= '0;
            mcand   <= '0;
            prod    <= '0;
            mplier  <= '0;
            neg     <= 1'b0;
            op_lat  <= OP_MUL;
            rd_lat  <= '0;
            acc     <= '0;
            wb_addr <= '0;
            wb_data <= '0;
        end else if (accept) begin
            count   <= '0;
            mcand   <= PROD_W'(magnitude(bus.op_a));
            mplier  <= magnitude(bus.op_b);
            prod    <= '0;
            neg     <= bus.op_a[DATA_W-1] ^ bus.op_b[DATA_W-1];
            op_lat  <= bus.op;
            rd_lat  <= bus.rd_addr;
            if (bus.op == OP_CLR) begin
                acc     <= '0;
                wb_addr <= bus.rd_addr;
                wb_data <= '0;
            end
        end else if (state == CALC) begin
            // shift-add step: multiplier consumed LSB first, multiplicand shifted up
            if (mplier[0]) prod <= prod + mcand;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 1'b1;
        end else if (state == FIX && !bus.flush) begin
            if (op_lat == OP_MAC) acc <= acc_sum;
            wb_addr <= rd_lat;
            case (op_lat)
                OP_MUL:  wb_data <= product[DATA_W-1:0];
                OP_MULH: wb_data <= product[PROD_W-1:DATA_W];
                default: wb_data <= acc_sum[DATA_W-1:0];
            endcase
        end
    end

    assign bus.ready   = ready;
    assign bus.busy    = (state == CALC) || (state == FIX);
    assign bus.done    = (state == WB);
    assign bus.wb_en   = (state == WB) && (op_lat != OP_CLR) && (wb_addr != '0);
    assign bus.wb_addr = wb_addr;
    assign bus.wb_data = wb_data;
    assign bus.acc_out = acc;
endmodule

// File: tb/tb_mac_exec_unit.sv
// Scoreboard bench for mac_exec_unit: directed ops push expected write-backs, a monitor checks each done pulse.
module tb_mac_exec_unit;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int ACC_W  = 64;

    typedef struct {
        logic              en;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [ACC_W-1:0]  acc;
    } exp_t;

    logic clk = 1'b0;
    logic reset;
    exp_t sbq[$];
    int   checks   = 0;
    int   errors   = 0;
    int   done_cnt = 0;
    int   cyc;
    int   d0;

    always #5 clk = ~clk;

    mac_exec_unit_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) bus ();

    mac_exec_unit #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest pending expectation.
    exp_t e;
    always @(negedge clk) begin
        if (!reset && bus.done) begin
            done_cnt++;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: got done=1 with wb_addr=%0d, expected no pending op", bus.wb_addr);
            end else begin
                e = sbq.pop_front();
                chk("wb_en",   64'(bus.wb_en),   64'(e.en));
                chk("wb_addr", 64'(bus.wb_addr), 64'(e.addr));
                chk("wb_data", 64'(bus.wb_data), 64'(e.data));
                chk("acc_out", 64'(bus.acc_out), e.acc);
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit push, input logic en,
                         input logic [31:0] data, input logic [63:0] acc);
        exp_t x;
        int   n = 0;
        while (!bus.ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.ready) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: got ready=0 after %0d cycles expected ready=1", n);
        end
        if (push) begin
            x.en = en; x.addr = rd; x.data = data; x.acc = acc;
            sbq.push_back(x);
        end
        bus.start   = 1'b1;
        bus.op      = op;
        bus.op_a    = a;
        bus.op_b    = b;
        bus.rd_addr = rd;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(output int c);
        c = 0;
        while (!bus.done && c < 100) begin
            @(posedge clk); #1;
            c++;
        end
    endtask

    initial begin
        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.flush   = 1'b0;
        bus.op      = 2'b00;
        bus.op_a    = '0;
        bus.op_b    = '0;
        bus.rd_addr = '0;
        @(posedge clk); #1;
        chk("rst_ready",   64'(bus.ready),   64'd1);
        chk("rst_busy",    64'(bus.busy),    64'd0);
        chk("rst_done",    64'(bus.done),    64'd0);
        chk("rst_wb_en",   64'(bus.wb_en),   64'd0);
        chk("rst_wb_addr", 64'(bus.wb_addr), 64'd0);
        chk("rst_wb_data", 64'(bus.wb_data), 64'd0);
        chk("rst_acc",     64'(bus.acc_out), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        // MUL 7 * -3 -> -21
        issue(2'b00, 32'd7, 32'hFFFF_FFFD, 5'd5, 1, 1'b1, 32'hFFFF_FFEB, 64'd0);
        wait_done(cyc);
        chk("mul_latency", 64'(cyc), 64'd33);
        issue(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd3, 1, 1'b1, 32'h4000_0000, 64'd0);
        wait_done(cyc);
        issue(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd4, 1, 1'b1, 32'hFFFF_FFFF, 64'd0);
        wait_done(cyc);

        // CLRACC then MAC chain issued from WB
        issue(2'b11, 32'd9, 32'd9, 5'd7, 1, 1'b0, 32'd0, 64'd0);
        wait_done(cyc);
        chk("clr_latency", 64'(cyc), 64'd0);
        issue(2'b10, 32'd5, 32'd6, 5'd1, 1, 1'b1, 32'd30, 64'd30);
        wait_done(cyc);
        issue(2'b10, 32'd2, 32'd3, 5'd2, 1, 1'b1, 32'd36, 64'd36);
        wait_done(cyc);
        issue(2'b10, 32'd3, 32'd4, 5'd0, 1, 1'b0, 32'd48, 64'd48);
        wait_done(cyc);
        @(posedge clk); #1;

        // flush together with start in IDLE drops the start
        bus.start = 1'b1; bus.flush = 1'b1; bus.op = 2'b00;
        @(posedge clk); #1;
        bus.start = 1'b0; bus.flush = 1'b0;
        chk("flush_start_busy",  64'(bus.busy),  64'd0);
        chk("flush_start_ready", 64'(bus.ready), 64'd1);

        // flush at counter=10
        d0 = done_cnt;
        issue(2'b00, 32'd9, 32'd9, 5'd6, 0, 1'b0, 32'd0, 64'd0);
        repeat (10) begin @(posedge clk); #1; end
        chk("flush_busy_before", 64'(bus.busy), 64'd1);
        bus.flush = 1'b1;
        @(posedge clk); #1;
        bus.flush = 1'b0;
        chk("flush_ready", 64'(bus.ready), 64'd1);
        chk("flush_busy",  64'(bus.busy),  64'd0);
        repeat (40) begin @(posedge clk); #1; end
        chk("flush_no_done", 64'(done_cnt - d0), 64'd0);
        chk("flush_acc",     64'(bus.acc_out),   64'd48);

        // start pulses while busy are ignored
        d0 = done_cnt;
        issue(2'b00, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 5'd9, 1, 1'b1, 32'd25, 64'd48);
        for (int i = 0; i < 10; i++) begin
            bus.start = 1'b1; bus.op = 2'b11; bus.rd_addr = 5'd1;
            @(posedge clk); #1;
            bus.start = 1'b0;
            @(posedge clk); #1;
        end
        chk("busy_ignore_busy", 64'(bus.busy), 64'd1);
        wait_done(cyc);
        repeat (5) begin @(posedge clk); #1; end
        chk("busy_one_done", 64'(done_cnt - d0), 64'd1);

        // reset mid-operation
        d0 = done_cnt;
        issue(2'b00, 32'd9, 32'd9, 5'd6, 0, 1'b0, 32'd0, 64'd0);
        repeat (10) begin @(posedge clk); #1; end
        reset = 1'b1;
        #1;
        chk("mid_rst_ready",   64'(bus.ready),   64'd1);
        chk("mid_rst_busy",    64'(bus.busy),    64'd0);
        chk("mid_rst_done",    64'(bus.done),    64'd0);
        chk("mid_rst_wb_en",   64'(bus.wb_en),   64'd0);
        chk("mid_rst_wb_addr", 64'(bus.wb_addr), 64'd0);
        chk("mid_rst_wb_data", 64'(bus.wb_data), 64'd0);
        chk("mid_rst_acc",     64'(bus.acc_out), 64'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (40) begin @(posedge clk); #1; end
        chk("mid_rst_no_done", 64'(done_cnt - d0), 64'd0);
        chk("sb_empty",        64'(sbq.size()),    64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
